// File: rtl/ddr_wr_packer.sv
// Packs 64-bit acquisition beats into 512-bit words for the DDR write FIFO,
// padding and flushing the partial word at end of frame, then signalling complete.
module ddr_wr_packer #(
    parameter int                   DIN_WIDTH  = 64,
    parameter int                   DOUT_WIDTH = 512,
    parameter logic [DIN_WIDTH-1:0] PAD_BEAT   = '0,
    parameter int                   CNT_WIDTH  = 32
) (
    input  logic                  clk_250m,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIN_WIDTH-1:0]  din,
    input  logic                  din_valid,
    input  logic                  din_last,
    output logic                  din_ready,
    output logic                  fifo_wr_en,
    output logic [DOUT_WIDTH-1:0] fifo_wr_data,
    input  logic                  fifo_full,
    input  logic                  fifo_prog_full,
    output logic                  complete,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic                  overflow
);

    localparam int N      = DOUT_WIDTH / DIN_WIDTH;
    localparam int LANE_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, PACK, FLUSH, DONE} state_t;

    state_t                state;
    logic [LANE_W-1:0]     lane;
    logic [DOUT_WIDTH-1:0] acc;
    logic [DOUT_WIDTH-1:0] packed_word;
    logic [CNT_WIDTH-1:0]  cnt_next;
    logic                  beat_ok;
    logic                  lane_top;

    assign din_ready = (state == PACK) && !fifo_prog_full;
    assign beat_ok   = din_valid && din_ready;
    assign lane_top  = (lane == LANE_W'(N - 1));
    assign cnt_next  = (word_cnt == '1) ? word_cnt : word_cnt + 1'b1;

    // Word as it stands once the current beat is merged; lanes above a final
    // beat take the pad value so a flushed word never carries stale data.
    always_comb begin
        // NOTE: default first so every path assigns packed_word and no latch is inferred.
        packed_word = acc;
        for (int i = 0; i < N; i++) begin
            if (LANE_W'(i) == lane)
                packed_word[i*DIN_WIDTH +: DIN_WIDTH] = din;
            else if ((LANE_W'(i) > lane) && din_last)
                packed_word[i*DIN_WIDTH +: DIN_WIDTH] = PAD_BEAT;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_250m or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lane         <= '0;
            acc          <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            complete     <= 1'b0;
            word_cnt     <= '0;
            overflow     <= 1'b0;
        end else begin
            fifo_wr_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    complete <= (state == DONE);
                    if (start) begin
                        state    <= PACK;
                        lane     <= '0;
                        word_cnt <= '0;
                        complete <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                PACK: begin
                    if (beat_ok) begin
                        acc  <= packed_word;
                        lane <= lane_top ? '0 : lane + 1'b1;
                        if (lane_top) begin
                            // A full word that cannot be written is dropped, not stalled.
                            if (fifo_full) begin
                                overflow <= 1'b1;
                            end else begin
                                fifo_wr_en   <= 1'b1;
                                fifo_wr_data <= packed_word;
                                word_cnt     <= cnt_next;
                            end
                            if (din_last)
                                state <= DONE;
                        end else if (din_last) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (!fifo_full) begin
                        fifo_wr_en   <= 1'b1;
                        fifo_wr_data <= acc;
                        word_cnt     <= cnt_next;
                        state        <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_wr_packer.sv
// Self-checking bench for ddr_wr_packer: randomized beats compared against a
// chunk-and-pad reference model of the expected FIFO writes and their timing.
module tb_ddr_wr_packer;

    localparam int          W   = 64;
    localparam int          OW  = 512;
    localparam int          N   = OW / W;
    localparam logic [63:0] PAD = 64'hDEAD_BEEF_0BAD_F00D;

    logic          clk_250m = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  din = '0;
    logic          din_valid = 1'b0;
    logic          din_last = 1'b0;
    logic          din_ready;
    logic          fifo_wr_en;
    logic [OW-1:0] fifo_wr_data;
    logic          fifo_full = 1'b0;
    logic          fifo_prog_full = 1'b0;
    logic          complete;
    logic [31:0]   word_cnt;
    logic          overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bad_wr = 0;
    int rise_cyc = -1;
    logic comp_d = 1'b0;

    logic [OW-1:0] got_q[$];
    int            got_cyc[$];
    logic [W-1:0]  sent_q[$];
    int            acc_cyc_q[$];

    ddr_wr_packer #(
        .DIN_WIDTH (W),
        .DOUT_WIDTH(OW),
        .PAD_BEAT  (PAD),
        .CNT_WIDTH (32)
    ) dut (
        .clk_250m      (clk_250m),
        .rst_n         (rst_n),
        .start         (start),
        .din           (din),
        .din_valid     (din_valid),
        .din_last      (din_last),
        .din_ready     (din_ready),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_wr_data  (fifo_wr_data),
        .fifo_full     (fifo_full),
        .fifo_prog_full(fifo_prog_full),
        .complete      (complete),
        .word_cnt      (word_cnt),
        .overflow      (overflow)
    );

    always #2 clk_250m = ~clk_250m;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_250m);
        #1;
        cyc++;
        if (fifo_wr_en) begin
            got_q.push_back(fifo_wr_data);
            got_cyc.push_back(cyc);
            if (fifo_full) bad_wr++;
        end
        if (complete && !comp_d) rise_cyc = cyc;
        comp_d = complete;
    endtask

    task automatic do_start();
        sent_q.delete();
        acc_cyc_q.delete();
        got_q.delete();
        got_cyc.delete();
        rise_cyc = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_word_cnt", word_cnt, 0);
        check("start_complete", complete, 0);
        check("start_overflow", overflow, 0);
    endtask

    // Presents n beats; pf_beat/pf_len hold prog_full over one beat, full_beat
    // raises fifo_full around the acceptance of that beat.
    task automatic send_beats(input int n, input bit seq, input bit with_last,
                              input int pf_beat, input int pf_len,
                              input int full_beat, input int gap_pct);
        logic [W-1:0] d;
        bit accepted;
        int budget;
        for (int i = 0; i < n; i++) begin
            d = seq ? W'(i) : {$urandom, $urandom};
            if ($urandom_range(0, 99) < gap_pct) begin
                din_valid = 1'b0;
                tick();
            end
            din       = d;
            din_valid = 1'b1;
            din_last  = with_last && (i == n - 1);
            if (i == pf_beat) begin
                fifo_prog_full = 1'b1;
                for (int k = 0; k < pf_len; k++) begin
                    #1;
                    check("pf_ready_low", din_ready, 0);
                    tick();
                end
                fifo_prog_full = 1'b0;
            end
            if (i == full_beat) fifo_full = 1'b1;
            accepted = 1'b0;
            budget   = 0;
            while (!accepted) begin
                #1;
                accepted = din_ready;
                tick();
                budget++;
                if (!accepted && budget > 50) begin
                    check("accept_timeout", 0, 1);
                    din_valid = 1'b0;
                    din_last  = 1'b0;
                    return;
                end
            end
            sent_q.push_back(d);
            acc_cyc_q.push_back(cyc);
            if (i == full_beat) begin
                din_valid = 1'b0;
                tick();
                fifo_full = 1'b0;
            end
        end
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    // Waits for complete, then compares every write against the chunked model.
    task automatic finish_frame(input int flush_hold, input bit exp_ovf, input int drop_chunk);
        logic [OW-1:0] exp_w[$];
        int            exp_c[$];
        logic [OW-1:0] word;
        int n, nchunks, e, idx, budget, nk;
        bit padded;
        if (flush_hold > 0) begin
            fifo_full = 1'b1;
            repeat (flush_hold) tick();
            fifo_full = 1'b0;
        end
        budget = 0;
        while (!complete && budget < 40) begin
            tick();
            budget++;
        end
        check("complete_seen", complete, 1);

        n       = sent_q.size();
        nchunks = (n + N - 1) / N;
        for (int j = 0; j < nchunks; j++) begin
            word = '0;
            for (int l = 0; l < N; l++) begin
                idx = j * N + l;
                word[l*W +: W] = (idx < n) ? sent_q[idx] : PAD;
            end
            e      = (j * N + N - 1 < n) ? j * N + N - 1 : n - 1;
            padded = (e - j * N) < N - 1;
            if (j != drop_chunk) begin
                exp_w.push_back(word);
                exp_c.push_back(acc_cyc_q[e] + (padded ? 1 + flush_hold : 0));
            end
        end

        check("num_writes", got_q.size(), exp_w.size());
        nk = (got_q.size() < exp_w.size()) ? got_q.size() : exp_w.size();
        for (int k = 0; k < nk; k++) begin
            check($sformatf("wr_data[%0d]", k), got_q[k], exp_w[k]);
            check($sformatf("wr_cycle[%0d]", k), got_cyc[k], exp_c[k]);
        end
        check("word_cnt", word_cnt, exp_w.size());
        check("overflow", overflow, exp_ovf);
        check("wr_while_full", bad_wr, 0);
        if (got_cyc.size() > 0)
            check("complete_rise", rise_cyc, got_cyc[got_cyc.size()-1] + 1);
    endtask

    initial begin
        // Reset state
        #5;
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_ready", din_ready, 0);
        check("rst_complete", complete, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_overflow", overflow, 0);
        check("rst_wr_data", fifo_wr_data, 0);
        rst_n = 1'b1;
        tick();
        tick();

        // 16 sequential beats, back-to-back: two full words, no bubble
        do_start();
        send_beats(16, 1'b1, 1'b1, -1, 0, -1, 0);
        finish_frame(0, 1'b0, -1);

        // 11 beats: second word padded in lanes 3..7
        do_start();
        send_beats(11, 1'b0, 1'b1, -1, 0, -1, 0);
        finish_frame(0, 1'b0, -1);

        // prog_full held 20 cycles mid-frame
        do_start();
        send_beats(24, 1'b0, 1'b1, 10, 20, -1, 20);
        finish_frame(0, 1'b0, -1);

        // FLUSH word waits 5 cycles on fifo_full, no overflow
        do_start();
        send_beats(11, 1'b0, 1'b1, -1, 0, -1, 0);
        finish_frame(5, 1'b0, -1);

        // fifo_full at the lane N-1 write of word 0: dropped, overflow sticky
        do_start();
        send_beats(16, 1'b0, 1'b1, -1, 0, 7, 0);
        finish_frame(0, 1'b1, 0);

        // Single beat with last in lane 0 still yields one padded word
        do_start();
        send_beats(1, 1'b0, 1'b1, -1, 0, -1, 0);
        finish_frame(0, 1'b0, -1);

        // Reset mid-frame after 3 beats
        do_start();
        send_beats(3, 1'b0, 1'b0, -1, 0, -1, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_wr_en", fifo_wr_en, 0);
        check("midrst_ready", din_ready, 0);
        check("midrst_complete", complete, 0);
        check("midrst_word_cnt", word_cnt, 0);
        check("midrst_wr_data", fifo_wr_data, 0);
        check("midrst_no_write", got_q.size(), 0);
        tick();
        tick();
        rst_n  = 1'b1;
        comp_d = 1'b0;
        tick();
        do_start();
        send_beats(8, 1'b0, 1'b1, -1, 0, -1, 0);
        finish_frame(0, 1'b0, -1);

        // Random-length frames with random gaps
        for (int r = 0; r < 4; r++) begin
            do_start();
            send_beats($urandom_range(1, 20), 1'b0, 1'b1, -1, 0, -1, 25);
            finish_frame(0, 1'b0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
